// File: rtl/accel_mac_array.sv
// accel_mac_array: CHANNELS unsigned accumulators sharing one iterative
// shift-add multiplier, programmed over the TinyQV 4-bit address / 8-bit
// data peripheral bus.
//
// Ports:
//   clk        project clock
//   rst        asynchronous active-high reset
//   ui_in      input PMOD (unused)
//   uo_out     bit1 busy, bit2 done, others 0 (bit0 left to UART TX)
//   address    register address
//   data_write one-cycle write strobe
//   data_in    write data
//   data_out   read data, combinational from address
//
// Build option: define ACCEL_SATURATE_EN to clamp a MAC carry-out to
// all-ones instead of wrapping. ovf is set in both builds.
//
// state  | meaning
// S_IDLE | waiting for a start; register writes accepted
// S_RUN  | one multiplier bit per cycle, DATA_W cycles
// S_WB   | write product (MUL) or sum (MAC) into the selected accumulator
module accel_mac_array #(
    parameter int DATA_W   = 8,
    parameter int CHANNELS = 4,
    parameter int ACC_W    = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int CNT_W  = $clog2(DATA_W);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_WB} state_t;

    state_t              state_q, state_d;
    logic [7:0]          ctrl_q;
    logic [DATA_W-1:0]   op_a_q, op_b_q;
    logic [PROD_W-1:0]   mcand_q, prod_q;
    logic [DATA_W-1:0]   mplier_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [3:0]          ch_q;
    logic                mode_q, done_q, ovf_q;
    logic [ACC_W-1:0]    acc_q [CHANNELS];

    logic                busy, wr_ok, ch_ok, start_go, clr_go, carry;
    logic [ACC_W-1:0]    acc_act, wb_val;
    logic [ACC_W:0]      mac_sum;
    logic [39:0]         acc_rd;
    logic                unused_ui;

    assign unused_ui = ^ui_in;
    assign busy      = (state_q != S_IDLE);
    assign uo_out    = {5'b0, done_q, busy, 1'b0};

    always_comb begin
        state_d  = state_q;
        wr_ok    = data_write && (state_q == S_IDLE);
        ch_ok    = int'(data_in[7:4]) < CHANNELS;
        clr_go   = wr_ok && (address == 4'h0) && ch_ok && data_in[1];
        start_go = wr_ok && (address == 4'h0) && ch_ok && !data_in[1] && data_in[0];
        unique case (state_q)
            S_IDLE:  if (start_go) state_d = S_RUN;
            S_RUN:   if (cnt_q == '0) state_d = S_WB;
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Accumulator of the channel being worked on, and the value WB stores.
    always_comb begin
        acc_act = '0;
        for (int c = 0; c < CHANNELS; c++)
            if (ch_q == 4'(c)) acc_act = acc_q[c];
        mac_sum = {1'b0, acc_act} + (ACC_W+1)'(prod_q);
        carry   = mac_sum[ACC_W];
        if (!mode_q)
            wb_val = ACC_W'(prod_q);
        else if (carry)
`ifdef ACCEL_SATURATE_EN
            wb_val = '1;
`else
            wb_val = mac_sum[ACC_W-1:0];
`endif
        else
            wb_val = mac_sum[ACC_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ctrl_q   <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            mcand_q  <= '0;
            prod_q   <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            ch_q     <= '0;
            mode_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) acc_q[c] <= '0;
        end else begin
            state_q <= state_d;
            if (wr_ok) begin
                case (address)
                    4'h0: ctrl_q <= {data_in[7:2], 2'b00};
                    4'h2: op_a_q[7:0] <= data_in;
                    4'h3: if (DATA_W > 8) op_a_q[DATA_W-1 -: 8] <= data_in;
                    4'h4: op_b_q[7:0] <= data_in;
                    4'h5: if (DATA_W > 8) op_b_q[DATA_W-1 -: 8] <= data_in;
                    default: ;
                endcase
            end
            if (start_go) begin
                mcand_q  <= PROD_W'(op_a_q);
                mplier_q <= op_b_q;
                prod_q   <= '0;
                cnt_q    <= CNT_W'(DATA_W - 1);
                ch_q     <= data_in[7:4];
                mode_q   <= data_in[2];
                done_q   <= 1'b0;
                ovf_q    <= 1'b0;
            end
            // Shifting the multiplicand left each step adds A<<i for bit i.
            if (state_q == S_RUN) begin
                if (mplier_q[0]) prod_q <= prod_q + mcand_q;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q - 1'b1;
            end
            if (state_q == S_WB) begin
                done_q <= 1'b1;
                if (mode_q && carry) ovf_q <= 1'b1;
            end
            for (int c = 0; c < CHANNELS; c++) begin
                if (clr_go && data_in[7:4] == 4'(c))
                    acc_q[c] <= '0;
                else if (state_q == S_WB && ch_q == 4'(c))
                    acc_q[c] <= wb_val;
            end
        end
    end

    // Out-of-range channel select leaves acc_rd at zero.
    always_comb begin
        acc_rd = '0;
        for (int c = 0; c < CHANNELS; c++)
            if (ctrl_q[7:4] == 4'(c)) acc_rd = 40'(acc_q[c]);
    end

    always_comb begin
        data_out = 8'h00;
        case (address)
            4'h0: data_out = ctrl_q;
            4'h1: data_out = {5'b0, ovf_q, done_q, busy};
            4'h2: data_out = op_a_q[7:0];
            4'h3: data_out = (DATA_W > 8) ? op_a_q[DATA_W-1 -: 8] : 8'h00;
            4'h4: data_out = op_b_q[7:0];
            4'h5: data_out = (DATA_W > 8) ? op_b_q[DATA_W-1 -: 8] : 8'h00;
            4'h8: data_out = acc_rd[7:0];
            4'h9: data_out = acc_rd[15:8];
            4'hA: data_out = acc_rd[23:16];
            4'hB: data_out = acc_rd[31:24];
            4'hC: data_out = acc_rd[39:32];
            default: data_out = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_accel_mac_array.sv
module tb_accel_mac_array;

    localparam int DATA_W   = 8;
    localparam int CHANNELS = 4;
    localparam int ACC_W    = 24;
    localparam logic [63:0] ACC_MAX = (64'd1 << ACC_W) - 64'd1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uo_out;
    logic [3:0] address = 4'h0;
    logic       data_write = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;

    int errors = 0;
    int checks = 0;

    accel_mac_array #(.DATA_W(DATA_W), .CHANNELS(CHANNELS), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .ui_in(ui_in), .uo_out(uo_out),
        .address(address), .data_write(data_write), .data_in(data_in),
        .data_out(data_out)
    );

    always #8 clk = ~clk;

    // Behavioural model: register contents, plus a countdown for the
    // busy window; the result lands when the countdown expires.
    logic [63:0] m_acc [CHANNELS];
    logic [63:0] m_a = 0, m_b = 0, m_prod = 0;
    logic [7:0]  m_ctrl = 0;
    logic        m_done = 0, m_ovf = 0, m_mac = 0;
    int          m_busy_cnt = 0;
    int          m_ch = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) m_acc[c] = 0;
            m_a = 0; m_b = 0; m_ctrl = 0; m_done = 0; m_ovf = 0; m_busy_cnt = 0;
        end else if (m_busy_cnt != 0) begin
            m_busy_cnt--;
            if (m_busy_cnt == 0) begin
                logic [63:0] s;
                if (!m_mac) s = m_prod;
                else begin
                    s = m_acc[m_ch] + m_prod;
                    if (s > ACC_MAX) begin
                        m_ovf = 1;
`ifdef ACCEL_SATURATE_EN
                        s = ACC_MAX;
`else
                        s = s & ACC_MAX;
`endif
                    end
                end
                m_acc[m_ch] = s;
                m_done = 1;
            end
        end else if (data_write) begin
            int ch;
            ch = int'(data_in[7:4]);
            case (address)
                4'h0: begin
                    m_ctrl = data_in & 8'hFC;
                    if (ch < CHANNELS) begin
                        if (data_in[1]) m_acc[ch] = 0;
                        else if (data_in[0]) begin
                            m_busy_cnt = DATA_W + 1;
                            m_done = 0; m_ovf = 0;
                            m_ch = ch; m_mac = data_in[2];
                            m_prod = m_a * m_b;
                        end
                    end
                end
                4'h2: m_a = (m_a & ~64'hFF) | 64'(data_in);
                4'h3: if (DATA_W > 8) m_a = (m_a & 64'hFF) | (64'(data_in) << 8);
                4'h4: m_b = (m_b & ~64'hFF) | 64'(data_in);
                4'h5: if (DATA_W > 8) m_b = (m_b & 64'hFF) | (64'(data_in) << 8);
                default: ;
            endcase
        end
    end

    function automatic logic [7:0] m_read(input logic [3:0] a);
        logic [63:0] t;
        int sel;
        sel = int'(m_ctrl[7:4]);
        case (a)
            4'h0: return m_ctrl;
            4'h1: return {5'b0, m_ovf, m_done, m_busy_cnt != 0};
            4'h2: return m_a[7:0];
            4'h3: return (DATA_W > 8) ? m_a[15:8] : 8'h00;
            4'h4: return m_b[7:0];
            4'h5: return (DATA_W > 8) ? m_b[15:8] : 8'h00;
            4'h8, 4'h9, 4'hA, 4'hB, 4'hC: begin
                if (sel >= CHANNELS) return 8'h00;
                t = m_acc[sel] >> (8 * (int'(a) - 8));
                return t[7:0];
            end
            default: return 8'h00;
        endcase
    endfunction

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("uo_out", uo_out, {5'b0, m_done, m_busy_cnt != 0, 1'b0});
        chk($sformatf("data_out@%0h", address), data_out, m_read(address));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        address = a; data_in = d; data_write = 1'b1;
        tick();
        data_write = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [7:0] exp, input string name);
        address = a;
        #2;
        chk(name, data_out, exp);
        tick();
    endtask

    task automatic wait_idle();
        int n = 0;
        while (uo_out[1] && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (uo_out[1]) begin
            errors++;
            $display("FAIL wait_idle: busy still %0b after %0d cycles", uo_out[1], n);
        end
    endtask

    initial begin
        int n;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset while idle after some activity
        wr(4'h2, 8'hAB); wr(4'h4, 8'hCD); wr(4'h0, 8'h35);
        wait_idle();
        rst = 1'b1;
        #1;
        chk("rst_idle_uo", uo_out, 8'h00);
        for (int a = 0; a < 16; a++) rd(4'(a), 8'h00, $sformatf("rst_idle_rd%0h", a));
        rst = 1'b0;
        tick();

        // MUL 0x0F * 0x11 on ch0
        wr(4'h2, 8'h0F); wr(4'h4, 8'h11); wr(4'h0, 8'h01);
        n = 0;
        while (uo_out[1] && n < 50) begin
            n++;
            tick();
        end
        chk("mul_busy_cycles", 8'(n), 8'(DATA_W + 1));
        rd(4'h8, 8'hFF, "mul_b0");
        rd(4'h9, 8'h00, "mul_b1");
        rd(4'hA, 8'h00, "mul_b2");
        rd(4'h1, 8'h02, "mul_status");
        chk("mul_uo", uo_out, 8'h04);

        // Three MACs of 0xFF*0xFF on ch2
        wr(4'h0, 8'h22);
        wr(4'h2, 8'hFF); wr(4'h4, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            wr(4'h0, 8'h25);
            wait_idle();
        end
        wr(4'h0, 8'h20);
        rd(4'h8, 8'h03, "mac_b0");
        rd(4'h9, 8'hFA, "mac_b1");
        rd(4'hA, 8'h02, "mac_b2");
        wr(4'h0, 8'h00);
        rd(4'h8, 8'hFF, "mac_ch0_kept");

        // 259 MACs on ch1 overflow 24 bits
        wr(4'h0, 8'h12);
        for (int i = 0; i < 259; i++) begin
            wr(4'h0, 8'h15);
            wait_idle();
        end
        wr(4'h0, 8'h10);
`ifdef ACCEL_SATURATE_EN
        rd(4'h8, 8'hFF, "ovf_b0"); rd(4'h9, 8'hFF, "ovf_b1"); rd(4'hA, 8'hFF, "ovf_b2");
`else
        rd(4'h8, 8'h03, "ovf_b0"); rd(4'h9, 8'hFB, "ovf_b1"); rd(4'hA, 8'h00, "ovf_b2");
`endif
        rd(4'h1, 8'h06, "ovf_status");

        // Writes during RUN are ignored
        wr(4'h2, 8'h03); wr(4'h4, 8'h05); wr(4'h0, 8'h01);
        wr(4'h2, 8'h7F); wr(4'h0, 8'h11);
        wait_idle();
        rd(4'h0, 8'h00, "busy_ctrl");
        rd(4'h2, 8'h03, "busy_opa");
        rd(4'h8, 8'h0F, "busy_ch0");

        // Reset in cycle 4 of RUN
        wr(4'h0, 8'h01);
        repeat (3) tick();
        #3;
        rst = 1'b1;
        #1;
        chk("rst_run_uo", uo_out, 8'h00);
        tick();
        rd(4'h8, 8'h00, "rst_run_ch0");
        rst = 1'b0;
        tick();
        for (int c = 1; c < CHANNELS; c++) begin
            wr(4'h0, 8'(c << 4));
            rd(4'h8, 8'h00, $sformatf("rst_run_ch%0d", c));
        end
        wr(4'h2, 8'h03); wr(4'h4, 8'h05); wr(4'h0, 8'h01);
        wait_idle();
        rd(4'h8, 8'h0F, "rst_run_restart");

        // Random bus traffic against the model
        for (int i = 0; i < 4000; i++) begin
            address    = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            data_write = ($urandom_range(0, 2) == 0);
            data_in    = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 15))};
            if (address != 4'h0) data_in = 8'($urandom);
            tick();
        end
        data_write = 1'b0;
        wait_idle();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
